// File: rtl/gpu_int_pkg.sv
// gpu_int_pkg: shared types and FLAGS register layout for the GPU interrupt controller.
// Optional feature macro: GPU_INT_LEVEL_EN (used by gpu_int_ctrl).
package gpu_int_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SVC  = 2'd2
    } state_t;

    // Largest source count the FLAGS bit fields can describe
    localparam int NUM_IRQ_MAX = 5;
    localparam int IDX_W       = 3;

    // FLAGS bit positions (write and read share IMASK and ENA positions;
    // the CLR write field sits where the latch read field is)
    localparam int IMASK_BIT = 3;
    localparam int ENA_LSB   = 4;
    localparam int CLR_LSB   = 9;
    localparam int LATCH_LSB = 9;

    // One bit per implemented source, so unused FLAGS bits stay zero
    function automatic logic [NUM_IRQ_MAX-1:0] src_mask(input int n);
        logic [NUM_IRQ_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < NUM_IRQ_MAX; i++) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/gpu_int_ctrl_if.sv
// gpu_int_ctrl_if: interrupt sources, FLAGS access and the request/ack link
// to the GPU program-control unit, bundled for gpu_int_ctrl.
//
// Handshake int_req/int_ack: the controller raises int_req with int_vec
// already valid; int_vec is held stable for as long as int_req is high.
// The request is accepted on the first GPU tick on which int_ack is
// sampled high while int_req is high; int_req then drops. The controller
// may also withdraw int_req without an ack if the pending source goes away.
interface gpu_int_ctrl_if import gpu_int_pkg::*; #(
    parameter int NUM_IRQ = NUM_IRQ_MAX
);
    logic [NUM_IRQ-1:0] irq_in;
    logic               flagwr;
    logic               flagrd;
    logic [31:0]        gpu_din;
    logic [15:0]        flag_dout;
    logic               int_req;
    logic [23:0]        int_vec;
    logic               int_ack;
    logic               imask;
    logic [NUM_IRQ-1:0] int_pend;

    // Register block / program control side
    modport master (
        output irq_in, flagwr, flagrd, gpu_din, int_ack,
        input  flag_dout, int_req, int_vec, imask, int_pend
    );

    // Interrupt controller side
    modport slave (
        input  irq_in, flagwr, flagrd, gpu_din, int_ack,
        output flag_dout, int_req, int_vec, imask, int_pend
    );
endinterface

// File: rtl/gpu_int_prio.sv
// gpu_int_prio: combinational priority encoder, highest set index wins.
module gpu_int_prio import gpu_int_pkg::*; (
    input  logic [NUM_IRQ_MAX-1:0] i_req,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_any
);

    // Scan upward so the highest requesting index is the one left standing
    always_comb begin
        o_idx = '0;
        o_any = 1'b0;
        for (int i = 0; i < NUM_IRQ_MAX; i++) begin
            if (i_req[i]) begin
                o_idx = IDX_W'(i);
                o_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/gpu_int_ctrl.sv
// gpu_int_ctrl: GPU interrupt controller. Latches sources, masks them with
// the FLAGS enables, offers the highest-priority vector to program control
// and holds IMASK until software clears it.
// Optional feature macro: GPU_INT_LEVEL_EN selects level-sensitive latching
// (default build: rising-edge latching).
module gpu_int_ctrl import gpu_int_pkg::*; #(
    parameter int          NUM_IRQ    = 5,
    parameter logic [23:0] VEC_BASE   = 24'hF03000,
    parameter int          VEC_STRIDE = 16
) (
    input  logic               sys_clk,
    input  logic               reset,
    input  logic               clk,
    gpu_int_ctrl_if.slave      bus,
    output state_t             o_dbg_state
);

    localparam logic [NUM_IRQ_MAX-1:0] SRC_MASK = src_mask(NUM_IRQ);

    logic                   r_old_clk;
    logic                   w_tick;
    logic [NUM_IRQ_MAX-1:0] w_irq;
    logic [NUM_IRQ_MAX-1:0] r_irq_prev;
    logic [NUM_IRQ_MAX-1:0] r_latch;
    logic [NUM_IRQ_MAX-1:0] r_ena;
    logic [NUM_IRQ_MAX-1:0] r_int_pend;
    logic                   r_imask;
    logic                   r_int_req;
    logic [23:0]            r_int_vec;
    logic [IDX_W-1:0]       r_idx;
    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   w_wr;
    logic                   w_imask_clr;
    logic [NUM_IRQ_MAX-1:0] w_clr;
    logic [NUM_IRQ_MAX-1:0] w_set;
    logic [NUM_IRQ_MAX-1:0] w_latch_nxt;
    logic [NUM_IRQ_MAX-1:0] w_ena_nxt;
    logic [NUM_IRQ_MAX-1:0] w_pending;
    logic [IDX_W-1:0]       w_prio_idx;
    logic                   w_prio_any;
    logic [23:0]            w_vec;
    logic                   w_issue;
    logic                   w_accept;
    logic                   w_withdraw;
    logic                   w_unused_bits;

    // GPU clock strobe history; a tick is its rising edge seen in sys_clk
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) r_old_clk <= 1'b0;
        else       r_old_clk <= clk;
    end

    assign w_tick = clk & ~r_old_clk;

    // Widen the source vector to the full FLAGS field width
    always_comb begin
        w_irq = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_irq[i] = bus.irq_in[i];
        end
    end

    assign w_wr        = w_tick & bus.flagwr;
    assign w_clr       = w_wr ? (bus.gpu_din[CLR_LSB +: NUM_IRQ_MAX] & SRC_MASK) : '0;
    assign w_ena_nxt   = w_wr ? (bus.gpu_din[ENA_LSB +: NUM_IRQ_MAX] & SRC_MASK) : r_ena;
    // IMASK can only be cleared by software; writing 1 is ignored
    assign w_imask_clr = w_wr & ~bus.gpu_din[IMASK_BIT];

`ifdef GPU_INT_LEVEL_EN
    // Level mode: a high input keeps re-setting its latch, so CLR only sticks once it is low
    assign w_set       = w_irq;
    assign w_latch_nxt = (r_latch & ~(w_clr & ~w_irq)) | w_set;
`else
    // Edge mode: input high now but low at the previous tick; set beats CLR
    assign w_set       = w_irq & ~r_irq_prev;
    assign w_latch_nxt = (r_latch & ~w_clr) | w_set;
`endif

    assign w_pending = r_latch & r_ena;

    gpu_int_prio u_prio (
        .i_req (w_pending),
        .o_idx (w_prio_idx),
        .o_any (w_prio_any)
    );

    assign w_vec = VEC_BASE + 24'(w_prio_idx) * 24'(VEC_STRIDE);

    // FSM state register, advancing on GPU ticks only
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset)       r_state <= IDLE;
        else if (w_tick) r_state <= w_state_nxt;
    end

    // FSM next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (!r_imask && w_prio_any)   w_state_nxt = REQ;
            REQ:  if (bus.int_ack)              w_state_nxt = SVC;
                  else if (!w_pending[r_idx])   w_state_nxt = IDLE;
            SVC:  if (!r_imask || w_imask_clr)  w_state_nxt = IDLE;
            default:                            w_state_nxt = IDLE;
        endcase
    end

    // FSM output decode: issue, accept or withdraw a request
    always_comb begin
        w_issue    = 1'b0;
        w_accept   = 1'b0;
        w_withdraw = 1'b0;
        case (r_state)
            IDLE: w_issue    = !r_imask && w_prio_any;
            REQ:  begin
                w_accept   = bus.int_ack;
                w_withdraw = !bus.int_ack && !w_pending[r_idx];
            end
            default: ;
        endcase
    end

    // Latches, enables, IMASK and the registered request/vector
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_irq_prev <= '0;
            r_latch    <= '0;
            r_ena      <= '0;
            r_int_pend <= '0;
            r_imask    <= 1'b0;
            r_int_req  <= 1'b0;
            r_int_vec  <= VEC_BASE;
            r_idx      <= '0;
        end else if (w_tick) begin
            r_irq_prev <= w_irq;
            r_latch    <= w_latch_nxt;
            r_ena      <= w_ena_nxt;
            r_int_pend <= w_latch_nxt & w_ena_nxt;
            if (w_accept)         r_imask <= 1'b1;
            else if (w_imask_clr) r_imask <= 1'b0;
            if (w_issue) begin
                r_int_req <= 1'b1;
                r_int_vec <= w_vec;
                r_idx     <= w_prio_idx;
            end else if (w_accept || w_withdraw) begin
                r_int_req <= 1'b0;
            end
        end
    end

    // FLAGS read port, zero when not selected
    always_comb begin
        bus.flag_dout = '0;
        if (bus.flagrd) begin
            bus.flag_dout[IMASK_BIT]                 = r_imask;
            bus.flag_dout[ENA_LSB +: NUM_IRQ_MAX]    = r_ena;
            bus.flag_dout[LATCH_LSB +: NUM_IRQ_MAX]  = r_latch;
        end
    end

    assign bus.int_req  = r_int_req;
    assign bus.int_vec  = r_int_vec;
    assign bus.imask    = r_imask;
    assign bus.int_pend = r_int_pend[NUM_IRQ-1:0];
    assign o_dbg_state  = r_state;

    // Data bits outside the FLAGS fields, and edge history in level mode, are intentionally dropped
    assign w_unused_bits = ^{bus.gpu_din[31:14], bus.gpu_din[2:0], r_irq_prev};

endmodule
